// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell (two half adders plus an OR), LSB first, WIDTH cycles per add.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' input port).

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_q, c_d;
    logic [CW-1:0]    n_q, n_d;

    logic             ha0_s, ha0_c, s_bit, ha1_c, c_out;
    logic [WIDTH-1:0] r_shifted;
    logic [WIDTH-1:0] b_load;
    logic             c_init;

    // Full-adder cell: sum and carry of the current LSBs plus running carry
    half_adder u_ha0 (.a(a_sh_q[0]), .b(b_sh_q[0]), .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.a(ha0_s),     .b(c_q),       .s(s_bit), .c(ha1_c));
    assign c_out = ha0_c | ha1_c;

    generate
        if (WIDTH == 1) begin : g_r_w1
            assign r_shifted = s_bit;
        end else begin : g_r_wn
            assign r_shifted = {s_bit, r_sh_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1: invert B and seed the carry
    assign b_load = sub ? ~op_b : op_b;
    assign c_init = sub;
`else
    assign b_load = op_b;
    assign c_init = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_d     = c_q;
        n_d     = n_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    a_sh_d  = op_a;
                    b_sh_d  = b_load;
                    c_d     = c_init;
                    n_d     = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                busy   = 1'b1;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = r_shifted;
                c_d    = c_out;
                n_d    = n_q + 1'b1;
                // Last bit: publish the complete result in the same edge
                if (n_q == CW'(WIDTH - 1)) begin
                    sum_d   = r_shifted;
                    carry_d = c_out;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            n_q     <= n_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

    // Exactly one of the three status outputs is high in every legal state
    a_status_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({ready, busy, done}));
    a_done_to_idle: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> ready);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized + directed bench for serial_adder_ctrl; expected results come from plain integer arithmetic.
// Define SERIAL_ADDER_SUB_EN for both files to exercise subtract mode.

module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int tests_run  = 0;
    int fail_count = 0;

    // Result the DUT outputs must be holding between completions
    logic [W-1:0] held_sum;
    logic         held_carry;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge where the DUT should be idle; returns at the negedge where it is idle again.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic hold_start, input logic wiggle, input int abort_after);
        logic [W:0] expv;
        check("ready_pre", ready, 1);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        sub   = s;
`ifdef SERIAL_ADDER_SUB_EN
        if (s) expv = {1'b0, a} + {1'b0, ~b} + 1'b1;
        else   expv = {1'b0, a} + {1'b0, b};
`else
        expv = {1'b0, a} + {1'b0, b};
`endif
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (wiggle && i == 2) begin
                op_a = W'($urandom);
                op_b = W'($urandom);
                sub  = ~sub;
            end
            check("busy", busy, 1);
            check("ready_busy", ready, 0);
            check("done_early", done, 0);
            check("sum_hold", sum, held_sum);
            check("carry_hold", carry, held_carry);
            if (i == abort_after) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                check("rst_ready", ready, 1);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_sum", sum, 0);
                check("rst_carry", carry, 0);
                held_sum   = '0;
                held_carry = 1'b0;
                @(negedge clk);
                check("rst_no_done", done, 0);
                rst_n = 1'b1;
                @(negedge clk);
                check("rst_no_done2", done, 0);
                $display("[TB] abort a=%02h b=%02h after %0d busy cycles", a, b, i);
                return;
            end
        end
        @(negedge clk);
        check("done", done, 1);
        check("busy_done", busy, 0);
        check("ready_done", ready, 0);
        check("sum", sum, expv[W-1:0]);
        check("carry", carry, expv[W]);
        held_sum   = expv[W-1:0];
        held_carry = expv[W];
        @(negedge clk);
        check("ready_post", ready, 1);
        check("done_once", done, 0);
        check("sum_keep", sum, held_sum);
        $display("[TB] op a=%02h b=%02h sub=%0b -> sum=%02h carry=%0b (exp %02h/%0b)",
                 a, b, s, sum, carry, expv[W-1:0], expv[W]);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        op_a       = '0;
        op_b       = '0;
        sub        = 1'b0;
        held_sum   = '0;
        held_carry = 1'b0;
        #2;
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_carry", carry, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 0);
        do_op(8'h50, 8'h0A, 1'b0, 1'b0, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 0);
        // Start held high and operands disturbed mid-op; next op begins right as ready returns
        do_op(8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1, 0);
        do_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 4);
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 0);
`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b0, 0);
        do_op(8'h07, 8'h05, 1'b1, 1'b0, 1'b0, 0);
`endif

        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, rs, 1'($urandom), 1'($urandom),
                  ($urandom_range(9) == 0) ? int'($urandom_range(W, 1)) : 0);
        end

        start = 1'b0;
        @(negedge clk);
        check("idle_end", ready, 1);
        check("idle_end_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
